muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the RV64 pipeline's EX stage, alongside the single-cycle ALU. It implements the M extension ops, including RV64 W variants, as a multi-cycle datapath with a valid/ready request and response handshake. A destination-register tag travels with each op, and a kill input supports pipeline flush.

---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64 M-extension multiply/divide unit for the EX stage.
//
// Ops (op_i): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM,    111 REMU
// word_i selects the W variant: 32-bit operands, result sign-extended from
// bit 31. High-half multiplies with word_i behave as MULW.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake (ready only in IDLE, not killed)
//   op_i, word_i, a_i, b_i, tag_i   operation, operands and destination tag
//   kill_i            pipeline flush; aborts anything in flight on the next edge
//   resp_valid_o/resp_ready_i response handshake
//   result_o, tag_o   registered result and its tag
//   busy_o            unit is not IDLE
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, a multiply completes as soon as the remaining multiplier
//   bits are all zero. When undefined, every non-special op takes N cycles.
module muldiv_unit #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [TAGW-1:0] tag_i,
  input  logic            kill_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [TAGW-1:0] tag_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              word_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   dsr;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign req_ready_o = (state == IDLE) && !kill_i;
  assign busy_o      = (state != IDLE);

  // Request decode: operand magnitudes, result sign and the special cases
  // that bypass iteration entirely.
  logic            is_div, a_signed, b_signed, sa, sb, neg_in;
  logic [31:0]     a_neg32, b_neg32;
  logic [XLEN-1:0] a_mag, b_mag, dividend, special_res;
  logic            div_zero, div_ovf;

  always_comb begin
    is_div   = op_i[2];
    a_signed = is_div ? !op_i[0] : (!word_i && (op_i == 3'b001 || op_i == 3'b010));
    b_signed = is_div ? !op_i[0] : (!word_i && (op_i == 3'b001));
    sa       = a_signed && (word_i ? a_i[31] : a_i[XLEN-1]);
    sb       = b_signed && (word_i ? b_i[31] : b_i[XLEN-1]);
    a_neg32  = 32'd0 - a_i[31:0];
    b_neg32  = 32'd0 - b_i[31:0];
    if (word_i) begin
      a_mag = sa ? XLEN'(a_neg32) : XLEN'(a_i[31:0]);
      b_mag = sb ? XLEN'(b_neg32) : XLEN'(b_i[31:0]);
    end else begin
      a_mag = sa ? ('0 - a_i) : a_i;
      b_mag = sb ? ('0 - b_i) : b_i;
    end
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_in   = (is_div && op_i[1]) ? sa : (sa ^ sb);
    div_zero = is_div && (word_i ? (b_i[31:0] == 32'd0) : (b_i == '0));
    div_ovf  = is_div && !op_i[0] &&
               (word_i ? (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == 32'hFFFF_FFFF)
                       : (a_i == {1'b1, {(XLEN-1){1'b0}}} && (&b_i)));
    dividend = word_i ? sext32(a_i[31:0]) : a_i;
    if (div_zero) special_res = op_i[1] ? dividend : '1;
    else          special_res = op_i[1] ? '0 : dividend;
  end

  // One iteration of both datapaths plus the sign fix-up and result select
  // that is registered on the final iteration edge.
  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN-1:0]   mplier_nx, rem_nx, quo_nx, q_fix, r_fix, full_res, final_res;
  logic [XLEN:0]     shifted, diff;
  logic              qbit, finish;
  logic [CW-1:0]     last_cnt;

  always_comb begin
    acc_nx    = mplier[0] ? (acc + mcand) : acc;
    mplier_nx = mplier >> 1;
    shifted   = {rem, quo[XLEN-1]};
    diff      = shifted - {1'b0, dsr};
    qbit      = !diff[XLEN];
    rem_nx    = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nx    = {quo[XLEN-2:0], qbit};
    prod      = neg_q ? ('0 - acc_nx) : acc_nx;
    q_fix     = neg_q ? ('0 - quo_nx) : quo_nx;
    r_fix     = neg_q ? ('0 - rem_nx) : rem_nx;
    if (op_q[2])                          full_res = op_q[1] ? r_fix : q_fix;
    else if (word_q || op_q[1:0] == 2'b00) full_res = prod[XLEN-1:0];
    else                                  full_res = prod[2*XLEN-1:XLEN];
    final_res = word_q ? sext32(full_res[31:0]) : full_res;
    last_cnt  = word_q ? CW'(31) : CW'(XLEN-1);
`ifdef MULDIV_EARLY_OUT_EN
    finish    = (cnt == last_cnt) || (!op_q[2] && (mplier_nx == '0));
`else
    finish    = (cnt == last_cnt);
`endif
  end

  // Control FSM and datapath registers. Kill has priority over everything
  // except reset. Word divides left-align the dividend so the same MSB-first
  // shift works for both widths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      op_q         <= '0;
      word_q       <= 1'b0;
      neg_q        <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      rem          <= '0;
      quo          <= '0;
      dsr          <= '0;
      resp_valid_o <= 1'b0;
      result_o     <= '0;
      tag_o        <= '0;
    end else if (kill_i) begin
      state        <= IDLE;
      resp_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            op_q   <= op_i;
            word_q <= word_i;
            neg_q  <= neg_in;
            tag_o  <= tag_i;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
            rem    <= '0;
            quo    <= word_i ? (a_mag << (XLEN-32)) : a_mag;
            dsr    <= b_mag;
            if (div_zero || div_ovf) begin
              state        <= DONE;
              resp_valid_o <= 1'b1;
              result_o     <= special_res;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt    <= cnt + 1'b1;
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier_nx;
          rem    <= rem_nx;
          quo    <= quo_nx;
          if (finish) begin
            state        <= DONE;
            resp_valid_o <= 1'b1;
            result_o     <= final_res;
          end
        end
        DONE: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (XLEN=64, TAGW=5).
// A forked monitor compares every valid response against an arithmetic
// reference model; directed ops also carry hand-computed literal results.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  op_i;
  logic        word_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic [4:0]  tag_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] result_o;
  logic [4:0]  tag_o;
  logic        busy_o;

  int checks;
  int errors;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  muldiv_unit #(.XLEN(64), .TAGW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_i         (op_i),
    .word_i       (word_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .tag_i        (tag_i),
    .kill_i       (kill_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .result_o     (result_o),
    .tag_o        (tag_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain wide arithmetic with the M-extension corner rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ua, ub, sa, sb, p;
    longint       sx, sy;
    int           wx, wy;
    logic [31:0]  ux, uy, r32;
    logic [63:0]  r;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    r  = '0;
    if (!op[2]) begin
      if (w) begin
        p = ua * ub;
        r = {{32{p[31]}}, p[31:0]};
      end else begin
        case (op[1:0])
          2'b00:   begin p = ua * ub; r = p[63:0];   end
          2'b01:   begin p = sa * sb; r = p[127:64]; end
          2'b10:   begin p = sa * ub; r = p[127:64]; end
          default: begin p = ua * ub; r = p[127:64]; end
        endcase
      end
    end else if (!w) begin
      if (b == 64'd0) r = op[1] ? a : '1;
      else if (!op[0]) begin
        sx = a;
        sy = b;
        if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
          r = op[1] ? 64'd0 : a;
        else
          r = op[1] ? 64'(sx % sy) : 64'(sx / sy);
      end else begin
        r = op[1] ? (a % b) : (a / b);
      end
    end else begin
      ux = a[31:0];
      uy = b[31:0];
      wx = a[31:0];
      wy = b[31:0];
      if (uy == 32'd0) r32 = op[1] ? ux : 32'hFFFF_FFFF;
      else if (!op[0]) begin
        if (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : ux;
        else r32 = op[1] ? 32'(wx % wy) : 32'(wx / wy);
      end else begin
        r32 = op[1] ? (ux % uy) : (ux / uy);
      end
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic bit isSpecial(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    bit bz, ovf;
    if (!op[2]) return 1'b0;
    bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    return bz || ovf;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle a response is presented it must match the
  // oldest outstanding expectation; it retires on the handshake.
  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (rst && resp_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp_valid", 64'(resp_valid_o), 64'd0);
        end else begin
          checkOutput("resp_result", result_o, exp_q[0].result);
          checkOutput("resp_tag", 64'(tag_o), 64'(exp_q[0].tag));
          if (resp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  // Presents one request (called just after a rising edge, unit IDLE). With
  // expect_resp it waits for the response and checks latency and literal;
  // it returns at the falling edge where resp_valid_o is first seen.
  task automatic applyStimulus(input logic [2:0] op, input logic w,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] tag, input bit expect_resp,
                               input bit use_lit, input logic [63:0] lit);
    exp_t e;
    int   lat;
    int   n;
    bit   special;
    bit   seen;
    e.result = model(op, w, a, b);
    e.tag    = tag;
    special  = isSpecial(op, w, a, b);
    n        = w ? 32 : 64;
    req_valid_i = 1'b1;
    op_i   = op;
    word_i = w;
    a_i    = a;
    b_i    = b;
    tag_i  = tag;
    if (expect_resp) exp_q.push_back(e);
    @(negedge clk);
    checkOutput("req_ready_idle", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 1'b0;
    a_i   = ~a;
    b_i   = ~b;
    tag_i = ~tag;
    if (!expect_resp) return;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        seen = 1'b1;
        break;
      end
      step();
      lat++;
    end
    if (!seen) begin
      checkOutput("resp_timeout", 64'd0, 64'd1);
    end else begin
`ifdef MULDIV_EARLY_OUT_EN
      if (!op[2] && !special)
        checkOutput("latency_bound", 64'(lat >= 2 && lat <= n + 1), 64'd1);
      else
`endif
      checkOutput("latency", 64'(lat), 64'(special ? 1 : n + 1));
      if (use_lit) checkOutput("literal_result", result_o, lit);
    end
  endtask

  task automatic runOp(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag,
                       input bit use_lit, input logic [63:0] lit);
    applyStimulus(op, w, a, b, tag, 1'b1, use_lit, lit);
    step();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    op_i         = '0;
    word_i       = 1'b0;
    a_i          = '0;
    b_i          = '0;
    tag_i        = '0;
    kill_i       = 1'b0;
    resp_ready_i = 1'b1;

    fork
      monitorLoop();
    join_none

    #1;
    checkOutput("reset_resp_valid", 64'(resp_valid_o), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    checkOutput("reset_tag", 64'(tag_o), 64'd0);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", 64'(req_ready_o), 64'd1);
    checkOutput("post_reset_busy", 64'(busy_o), 64'd0);
    step();

    $display("[TB] directed multiply/divide vectors");
    runOp(3'b000, 1'b0, 64'd3, 64'd5, 5'd3, 1'b1, 64'd15);
    runOp(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp(3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd5, 1'b1, 64'h1);
    runOp(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp(3'b101, 1'b0, 64'd5, 64'd0, 5'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp(3'b111, 1'b0, 64'd5, 64'd0, 5'd10, 1'b1, 64'd5);
    runOp(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 1'b1,
          64'h8000_0000_0000_0000);
    runOp(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 1'b1, 64'd0);
    runOp(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd13, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp(3'b100, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 5'd14, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFA);
    runOp(3'b110, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 5'd15, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE);
    runOp(3'b101, 1'b1, 64'hDEAD_BEEF_8000_0001, 64'h0000_0001_0000_0000, 5'd16, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF);
    runOp(3'b111, 1'b1, 64'hDEAD_BEEF_8000_0001, 64'h0000_0001_0000_0000, 5'd17, 1'b1,
          64'hFFFF_FFFF_8000_0001);
    runOp(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd18, 1'b1,
          64'hFFFF_FFFF_8000_0000);
    runOp(3'b001, 1'b1, 64'h0001_2345, 64'h0001_0000, 5'd19, 1'b1, 64'h2345_0000);
    runOp(3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd20, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd21, 1'b1, 64'd1);
    runOp(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd22, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE);

    $display("[TB] model-only vectors");
    runOp(3'b000, 1'b0, 64'hDEAD_BEEF_CAFE_BABE, 64'h1234_5678_9ABC_DEF0, 5'd1, 1'b0, 64'd0);
    runOp(3'b001, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 5'd2, 1'b0, 64'd0);
    runOp(3'b010, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd23, 1'b0, 64'd0);
    runOp(3'b101, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0012_3457, 5'd24, 1'b0, 64'd0);
    runOp(3'b110, 1'b0, 64'h8000_0000_0000_0001, 64'd10, 5'd25, 1'b0, 64'd0);
    runOp(3'b011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd26, 1'b0, 64'd0);

    $display("[TB] response back-pressure");
    resp_ready_i = 1'b0;
    applyStimulus(3'b101, 1'b0, 64'd1000, 64'd7, 5'd27, 1'b1, 1'b1, 64'd142);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      checkOutput("stall_resp_valid", 64'(resp_valid_o), 64'd1);
      checkOutput("stall_busy", 64'(busy_o), 64'd1);
      checkOutput("stall_not_ready", 64'(req_ready_o), 64'd0);
    end
    step();
    resp_ready_i = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    checkOutput("after_accept_valid", 64'(resp_valid_o), 64'd0);
    checkOutput("after_accept_busy", 64'(busy_o), 64'd0);
    step();

    $display("[TB] kill while holding a result");
    resp_ready_i = 1'b0;
    applyStimulus(3'b000, 1'b0, 64'd6, 64'd7, 5'd28, 1'b1, 1'b1, 64'd42);
    step();
    kill_i = 1'b1;
    @(negedge clk);
    checkOutput("kill_done_ready_low", 64'(req_ready_o), 64'd0);
    step();
    kill_i = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    resp_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("kill_done_valid", 64'(resp_valid_o), 64'd0);
    checkOutput("kill_done_busy", 64'(busy_o), 64'd0);
    step();

    $display("[TB] kill during a divide");
    applyStimulus(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd3, 5'd29, 1'b0, 1'b0, 64'd0);
    repeat (9) step();
    kill_i = 1'b1;
    @(negedge clk);
    checkOutput("kill_busy_before", 64'(busy_o), 64'd1);
    step();
    kill_i = 1'b0;
    @(negedge clk);
    checkOutput("kill_busy_after", 64'(busy_o), 64'd0);
    checkOutput("kill_valid_after", 64'(resp_valid_o), 64'd0);
    repeat (80) step();

    $display("[TB] kill beats accept");
    req_valid_i = 1'b1;
    kill_i      = 1'b1;
    op_i        = 3'b000;
    word_i      = 1'b0;
    a_i         = 64'd2;
    b_i         = 64'd2;
    tag_i       = 5'd30;
    @(negedge clk);
    checkOutput("kill_accept_ready", 64'(req_ready_o), 64'd0);
    step();
    req_valid_i = 1'b0;
    kill_i      = 1'b0;
    @(negedge clk);
    checkOutput("kill_accept_busy", 64'(busy_o), 64'd0);
    step();

    runOp(3'b000, 1'b0, 64'd9, 64'd9, 5'd31, 1'b1, 64'd81);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(3'b000, 1'b0, 64'd5, 64'd7, 5'd26, 1'b0, 1'b0, 64'd0);
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(resp_valid_o), 64'd0);
    checkOutput("async_reset_result", result_o, 64'd0);
    checkOutput("async_reset_tag", 64'(tag_o), 64'd0);
    checkOutput("async_reset_busy", 64'(busy_o), 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release_ready", 64'(req_ready_o), 64'd1);
    checkOutput("pending_responses", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
